// File: rtl/timer_alarm_pkg.sv
// Shared alarm definitions: FSM state encoding and the interval-width macro
// used alongside the timer CSR defines.
`define TIMER_ALARM_IW(dw) (2*(dw))

package timer_alarm_pkg;

  typedef enum logic [1:0] {
    ALARM_IDLE = 2'd0,
    ALARM_RUN  = 2'd1,
    ALARM_DONE = 2'd2
  } alarm_state_e;

endpackage

// File: rtl/timer_alarm_cnt.sv
// Loadable down-counter for the alarm interval. Load beats decrement, and the
// count saturates at zero so it never wraps.
module timer_alarm_cnt #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cke_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         is_one_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (cke_i) begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/timer_alarm_core.sv
// Alarm timer: stages a two-word interval, counts it down and raises a sticky
// interrupt (with overrun tracking) on each expiry, one-shot or auto-reload.
module timer_alarm_core
  import timer_alarm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cke_i,
  input  logic                  en_i,
  input  logic                  periodic_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  wstrb_lo_i,
  input  logic                  wstrb_hi_i,
  input  logic                  irq_clr_i,
  output logic [2*DATA_W-1:0]   count_o,
  output logic                  irq_o,
  output logic                  overrun_o,
  output logic                  expired_o,
  output logic                  busy_o
);

  localparam int IW = `TIMER_ALARM_IW(DATA_W);

  alarm_state_e      state_q, state_d;
  logic [DATA_W-1:0] staged_lo_q, staged_lo_d;
  logic [IW-1:0]     load_q, load_d;
  logic              irq_q, irq_d;
  logic              overrun_q, overrun_d;
  logic              expired_q, expired_d;

  logic [IW-1:0]     commit_val;
  logic [IW-1:0]     cnt_load_val;
  logic [IW-1:0]     cnt_value;
  logic              commit, expire, cnt_load, cnt_en, cnt_is_one;

  // A commit always takes the previously staged low word, even when the low
  // strobe fires in the same cycle.
  assign commit     = wstrb_hi_i;
  assign commit_val = {wdata_i, staged_lo_q};
  assign cnt_en     = (state_q == ALARM_RUN) && en_i;
  assign expire     = cnt_en && cnt_is_one && !commit;
  assign cnt_load   = commit || (expire && periodic_i);
  assign cnt_load_val = commit ? commit_val : load_q;

  timer_alarm_cnt #(
    .W(IW)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cke_i      (cke_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .count_o    (cnt_value),
    .is_one_o   (cnt_is_one)
  );

  always_comb begin
    state_d     = state_q;
    staged_lo_d = staged_lo_q;
    load_d      = load_q;
    irq_d       = irq_q;
    overrun_d   = overrun_q;
    expired_d   = expire;

    if (wstrb_lo_i) begin
      staged_lo_d = wdata_i;
    end

    if (commit) begin
      load_d  = commit_val;
      state_d = (commit_val == '0) ? ALARM_IDLE : ALARM_RUN;
    end else if (expire && !periodic_i) begin
      state_d = ALARM_DONE;
    end

    // Set beats clear; a clear coinciding with an expiry is not an overrun.
    if (expire) begin
      irq_d     = 1'b1;
      overrun_d = irq_clr_i ? 1'b0 : (overrun_q | irq_q);
    end else if (irq_clr_i) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ALARM_IDLE;
      staged_lo_q <= '0;
      load_q      <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      expired_q   <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      staged_lo_q <= staged_lo_d;
      load_q      <= load_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
      expired_q   <= expired_d;
    end
  end

  assign count_o   = cnt_value;
  assign irq_o     = irq_q;
  assign overrun_o = overrun_q;
  assign expired_o = expired_q;
  assign busy_o    = (state_q == ALARM_RUN);

endmodule

// File: tb/tb_timer_alarm_core.sv
// Self-checking bench for timer_alarm_core: a vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_timer_alarm_core;

  logic        clk = 1'b0;
  logic        rst, cke, en, per, lo, hi, clr;
  logic [31:0] wdata;
  logic [63:0] count;
  logic        irq, ovr, expd, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timer_alarm_core #(.DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cke_i      (cke),
    .en_i       (en),
    .periodic_i (per),
    .wdata_i    (wdata),
    .wstrb_lo_i (lo),
    .wstrb_hi_i (hi),
    .irq_clr_i  (clr),
    .count_o    (count),
    .irq_o      (irq),
    .overrun_o  (ovr),
    .expired_o  (expd),
    .busy_o     (busy)
  );

  // Behavioural model: a remaining-count number plus a "running" flag.
  logic [31:0] m_staged;
  logic [63:0] m_load, m_cnt;
  logic        m_running, m_irq, m_ovr, m_exp;

  task automatic model_step();
    logic [63:0] cv;
    logic        fire;
    if (rst) begin
      m_staged = 0; m_load = 0; m_cnt = 0;
      m_running = 0; m_irq = 0; m_ovr = 0; m_exp = 0;
    end else if (cke) begin
      cv   = {wdata, m_staged};
      fire = m_running && en && (m_cnt == 1) && !hi;
      if (lo) m_staged = wdata;
      m_exp = fire;
      if (hi) begin
        m_load = cv; m_cnt = cv; m_running = (cv != 0);
      end else if (fire) begin
        if (per) m_cnt = m_load;
        else begin m_cnt = 0; m_running = 0; end
      end else if (m_running && en) begin
        m_cnt = m_cnt - 1;
      end
      if (fire) begin
        m_ovr = clr ? 1'b0 : (m_ovr | m_irq);
        m_irq = 1'b1;
      end else if (clr) begin
        m_irq = 1'b0; m_ovr = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic e, input logic p,
                       input logic l, input logic h, input logic cl, input logic [31:0] wd);
    rst = r; cke = c; en = e; per = p; lo = l; hi = h; clr = cl; wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic p,
                      input logic l, input logic h, input logic cl, input logic [31:0] wd);
    drive(r, c, e, p, l, h, cl, wd);
    tick();
  endtask

  typedef struct {
    logic        rst, cke, en, per, lo, hi, clr;
    logic [31:0] wdata;
    logic [63:0] e_cnt;
    logic        e_irq, e_ovr, e_exp, e_busy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n, g;
    drive(1, 1, 0, 0, 0, 0, 0, 0);

    // rst cke en per lo hi clr wdata | cnt irq ovr exp busy
    vecs[0]  = '{1,1,0,0,0,0,0, 32'd0, 64'd0, 0,0,0,0};
    vecs[1]  = '{0,1,0,0,1,0,0, 32'd5, 64'd0, 0,0,0,0};
    vecs[2]  = '{0,1,1,0,0,1,0, 32'd0, 64'd5, 0,0,0,1};
    vecs[3]  = '{0,1,1,0,0,0,0, 32'd0, 64'd4, 0,0,0,1};
    vecs[4]  = '{0,1,1,0,0,0,0, 32'd0, 64'd3, 0,0,0,1};
    vecs[5]  = '{0,1,1,0,0,0,0, 32'd0, 64'd2, 0,0,0,1};
    vecs[6]  = '{0,1,1,0,0,0,0, 32'd0, 64'd1, 0,0,0,1};
    vecs[7]  = '{0,1,1,0,0,0,0, 32'd0, 64'd0, 1,0,1,0};
    vecs[8]  = '{0,1,1,0,0,0,0, 32'd0, 64'd0, 1,0,0,0};
    vecs[9]  = '{0,0,1,1,1,1,1, 32'd9, 64'd0, 1,0,0,0};
    vecs[10] = '{0,1,0,0,0,0,1, 32'd0, 64'd0, 0,0,0,0};
    vecs[11] = '{0,1,0,0,1,0,0, 32'd3, 64'd0, 0,0,0,0};
    vecs[12] = '{0,1,0,0,0,1,0, 32'd0, 64'd3, 0,0,0,1};
    vecs[13] = '{0,1,0,0,0,0,0, 32'd0, 64'd3, 0,0,0,1};
    vecs[14] = '{0,1,1,0,0,0,0, 32'd0, 64'd2, 0,0,0,1};
    vecs[15] = '{1,0,1,0,0,0,0, 32'd0, 64'd0, 0,0,0,0};

    // Reset then idle.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_cnt", count, 0);
    chk("idle_irq", irq, 0);
    chk("idle_busy", busy, 0);
    $display("idle: cnt=%0d irq=%0b busy=%0b", count, irq, busy);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].cke, vecs[i].en, vecs[i].per,
           vecs[i].lo, vecs[i].hi, vecs[i].clr, vecs[i].wdata);
      chk($sformatf("vec%0d_cnt", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
      chk($sformatf("vec%0d_ovr", i), ovr, vecs[i].e_ovr);
      chk($sformatf("vec%0d_exp", i), expd, vecs[i].e_exp);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      $display("vec %0d: cnt=%0d irq=%0b ovr=%0b exp=%0b busy=%0b", i, count, irq, ovr, expd, busy);
    end

    // Periodic reload with an en_i pause.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 1, 0, 1, 0, 0);
    chk("per_load", count, 3);
    n = 0;
    do begin step(0, 1, 1, 1, 0, 0, 0, 0); n++; end while (!expd && n < 20);
    chk("per_gap1", n, 3);
    chk("per_cnt_reload", count, 3);
    chk("per_ovr_first", ovr, 0);
    g = 1; step(0, 1, 1, 1, 0, 0, 0, 0);
    repeat (4) begin step(0, 1, 0, 1, 0, 0, 0, 0); g++; end
    chk("per_hold_cnt", count, 2);
    do begin step(0, 1, 1, 1, 0, 0, 0, 0); g++; end while (!expd && g < 30);
    chk("per_gap2", g, 7);
    chk("per_ovr_second", ovr, 1);
    chk("per_irq", irq, 1);
    step(0, 1, 0, 1, 0, 0, 1, 0);
    chk("per_clr_irq", irq, 0);
    chk("per_clr_ovr", ovr, 0);
    $display("periodic: gap1=%0d gap2=%0d", n, g);

    // Wide commit, lo-only write, same-cycle lo/hi, zero commit.
    step(0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0, 1, 0, 32'h1);
    chk("wide_cnt", count, 64'h1_FFFF_FFFF);
    step(0, 1, 0, 0, 1, 0, 0, 32'd7);
    chk("wide_lo_only", count, 64'h1_FFFF_FFFF);
    step(0, 1, 0, 0, 1, 0, 0, 32'd0);
    step(0, 1, 0, 0, 1, 1, 0, 32'd2);
    chk("same_cycle_commit", count, 64'h2_0000_0000);
    step(0, 1, 0, 0, 0, 1, 0, 32'd0);
    chk("same_cycle_staged", count, 64'd2);
    step(0, 1, 0, 0, 1, 0, 0, 32'd0);
    step(0, 1, 0, 0, 0, 1, 0, 32'd0);
    chk("zero_commit_busy", busy, 0);
    chk("zero_commit_cnt", count, 0);
    $display("wide: cnt=0x%0h busy=%0b", count, busy);

    // Commit in the expiry cycle wins.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 32'd2);
    step(0, 1, 0, 0, 0, 1, 0, 32'd0);
    step(0, 1, 0, 0, 1, 0, 0, 32'd10);
    step(0, 1, 1, 0, 0, 0, 0, 32'd0);
    step(0, 1, 1, 0, 0, 1, 0, 32'd0);
    chk("coll_commit_cnt", count, 10);
    chk("coll_commit_exp", expd, 0);
    chk("coll_commit_irq", irq, 0);

    // Clear in the expiry cycle: irq stays set, no overrun.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 32'd1);
    step(0, 1, 0, 0, 0, 1, 0, 32'd0);
    step(0, 1, 1, 0, 0, 0, 0, 32'd0);
    chk("coll_first_irq", irq, 1);
    step(0, 1, 0, 0, 0, 1, 0, 32'd0);
    step(0, 1, 1, 0, 0, 0, 1, 32'd0);
    chk("coll_clr_irq", irq, 1);
    chk("coll_clr_ovr", ovr, 0);
    chk("coll_clr_exp", expd, 1);
    $display("collisions: irq=%0b ovr=%0b", irq, ovr);

    // Reset mid-count with cke low.
    step(0, 1, 0, 0, 1, 0, 0, 32'd100);
    step(0, 1, 1, 1, 0, 1, 0, 32'd0);
    chk("rst_pre_cnt", count, 100);
    step(1, 0, 1, 1, 0, 0, 0, 32'd0);
    chk("rst_cnt", count, 0);
    chk("rst_busy", busy, 0);

    // Randomized run against the model.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      logic r, c, e, p, l, h, cl;
      logic [31:0] wd;
      r  = ($urandom_range(0, 79) == 0);
      c  = ($urandom_range(0, 7) != 0);
      e  = ($urandom_range(0, 3) != 0);
      p  = $urandom_range(0, 1);
      l  = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 9) == 0);
      if (h) wd = ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0;
      else   wd = $urandom_range(0, 6);
      step(r, c, e, p, l, h, cl, wd);
      chk("rand_cnt", count, m_cnt);
      chk("rand_irq", irq, m_irq);
      chk("rand_ovr", ovr, m_ovr);
      chk("rand_exp", expd, m_exp);
      chk("rand_busy", busy, m_running);
      $display("rand %0d: cnt=0x%0h irq=%0b ovr=%0b exp=%0b busy=%0b", i, count, irq, ovr, expd, busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_alarm_core.md
Name: timer_alarm_core

Overview:
- Write-side counterpart of the free-running time counter.
- Software writes a 2*DATA_W-bit interval as low/high words. The block counts it down and raises an interrupt at expiry.
- Supports one-shot and periodic auto-reload modes.
- Sits behind the timer CSR block; irq_o goes to the interrupt controller.

Parameters:
- DATA_W, 32, CSR word width; the interval and counter are 2*DATA_W bits wide.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset; reset is synchronous and active-high
- cke_i  in  1  clock enable; when low, all state holds and all inputs are ignored
- en_i  in  1  count enable; when low, the counter holds and the state is unchanged
- periodic_i  in  1  1 = auto-reload at expiry, 0 = one-shot; sampled at expiry
- wdata_i  in  DATA_W  CSR write data
- wstrb_lo_i  in  1  write strobe for the interval low word (staged, not committed)
- wstrb_hi_i  in  1  write strobe for the high word; commits {wdata_i, staged_lo}
- irq_clr_i  in  1  clears irq_o and overrun_o
- count_o  out  2*DATA_W  live remaining count
- irq_o  out  1  sticky expiry interrupt
- overrun_o  out  1  sticky flag: expiry occurred while irq_o was already set
- expired_o  out  1  one-cycle pulse on each expiry
- busy_o  out  1  high while state == RUN

Behaviour:
- Reset (rst_i=1 at a clock edge, has priority over cke_i):
  - staged_lo=0, load=0, count_o=0, state=IDLE.
  - irq_o=0, overrun_o=0, expired_o=0, busy_o=0.
- All transitions below require cke_i=1.
- wstrb_lo_i: staged_lo <= wdata_i. No other effect.
- wstrb_hi_i (commit): load <= {wdata_i, staged_lo} and count_o <= the same value, visible next cycle.
  - Value == 0 -> state IDLE.
  - Otherwise -> state RUN.
  - Independent of en_i.
- Same-cycle wstrb_lo_i and wstrb_hi_i: the commit uses the new wdata_i as the high word and the OLD staged_lo as the low word; staged_lo also updates.
- States:
  - IDLE: counter holds; leave only by a nonzero commit.
  - RUN: when en_i=1, decrement count_o each cycle.
  - DONE: count_o=0; leave only by a commit.
- Expiry: in RUN with en_i=1 and count_o==1. In that cycle:
  - expired_o=1 next cycle, for exactly one cycle.
  - irq_o <= 1.
  - If irq_o was already 1 (and no irq_clr_i this cycle), overrun_o <= 1.
  - periodic_i=1: count_o <= load, stay in RUN. The period is exactly `load` enabled cycles.
  - periodic_i=0: count_o <= 0, state DONE.
- Latency: commit of N, en_i held high -> expired_o asserts N cycles after the cycle in which count_o first shows N.
- Commit in the same cycle as an expiry: the commit wins; no expiry, irq_o unchanged.
- irq_clr_i in the same cycle as an expiry: set wins, so irq_o=1. overrun_o is cleared, because a clear plus a new expiry is not an overrun.
- irq_clr_i alone: irq_o and overrun_o go to 0 next cycle.
- en_i low mid-count: count_o holds; resume on en_i high with no lost or extra cycles.
- Reset mid-count: everything returns to reset values; staged_lo is lost.
- The counter never wraps below 0; count_o==0 occurs only in IDLE or DONE.
- load == 1 with periodic_i=1: expiry every enabled cycle. irq_o stays 1; overrun_o sets on the second expiry.

Decomposition:
- Shared package, alongside the iob_timer CSR defines:
  - State encoding localparams: ALARM_IDLE=2'd0, ALARM_RUN=2'd1, ALARM_DONE=2'd2.
  - Interval width macro: 2*DATA_W.
- One natural sub-module: timer_alarm_cnt.
  - Loadable down-counter with synchronous reset, cke, load and en inputs.
  - Outputs the count and an is_one flag.
  - The top level holds the FSM, staging and load registers, and the irq/overrun flags.

Test Plan:
- Reset then idle: 10 cycles with no strobes -> count_o=0, irq_o=0, busy_o=0, state IDLE.
- One-shot: write lo=5, hi=0, periodic_i=0, en_i=1 -> count_o goes 5,4,3,2,1,0. expired_o pulses once in the cycle count_o becomes 0. irq_o=1, busy_o=0. No further pulses after 20 more cycles.
- Periodic with pause: load=3, periodic_i=1 -> expired_o every 3 cycles. Drop en_i for 4 cycles mid-count -> count holds and the next expiry is delayed by exactly 4. The second uncleared expiry sets overrun_o. irq_clr_i clears both flags.
- 64-bit commit: write lo=0xFFFF_FFFF then hi=0x1.
  - count_o=0x1_FFFF_FFFF after commit.
  - A lo-only write of 7 afterwards leaves count_o and load unchanged.
  - A commit of hi=0 with staged lo=0 -> state IDLE.
- Collisions:
  - Commit of 10 in the expiry cycle -> no expired_o, count_o=10.
  - irq_clr_i in the expiry cycle -> irq_o=1, overrun_o=0.
- cke/reset:
  - cke_i=0 for 5 cycles with strobes toggling -> no state change.
  - rst_i mid-count (count=100) -> all outputs 0 on the next cycle, including when cke_i=0.
